// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU nibble-entry front end.
//   NIBBLE_W             : width of one switch nibble
//   state_t              : entry FSM encoding (ST_COLLECT / ST_PRESENT)
//   DEF_FRAME_NIBBLES    : default nibbles per frame
//   DEF_DEBOUNCE_CYCLES  : default debounce window in synced cycles
package mpu_pkg;

   localparam int unsigned NIBBLE_W            = 4;
   localparam int unsigned DEF_FRAME_NIBBLES   = 4;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 2;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

endpackage

// File: rtl/mpu_nibble_entry_if.sv
// Frame handshake bundle between the nibble-entry front end and the MPU.
//   frame_data  : packed frame, first-entered nibble in the MSBs
//   frame_valid : frame complete and held
//   frame_ready : MPU accepts the frame
// master = entry front end, slave = MPU.
interface mpu_nibble_entry_if
   import mpu_pkg::*;
#(
   parameter int unsigned FRAME_NIBBLES = DEF_FRAME_NIBBLES
);
   localparam int unsigned FRAME_W = NIBBLE_W * FRAME_NIBBLES;

   logic [FRAME_W-1:0] frame_data;
   logic               frame_valid;
   logic               frame_ready;

   modport master (
      output frame_data,
      output frame_valid,
      input  frame_ready
   );

   modport slave (
      input  frame_data,
      input  frame_valid,
      output frame_ready
   );

endinterface

// File: rtl/mpu_nibble_entry_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-window debounce, rising-edge pulse.
//   clk, rst   : clock, asynchronous active-high reset
//   raw_in     : raw (asynchronous) button level
//   level      : debounced level
//   rise_pulse : one-cycle pulse, coincident with the 0->1 flip of level
module btn_debounce
   import mpu_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic level,
   output logic rise_pulse
);

   localparam int unsigned    CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta_q;
   logic             sync_q;
   logic [CNT_W-1:0] cnt_q;
   logic             flip_c;

   // Synced level has disagreed for the full window this cycle.
   assign flip_c = (sync_q != level) && (cnt_q == CNT_LAST);

   // Sync chain, stable counter (restarts on any agreement) and edge pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q     <= 1'b0;
         sync_q     <= 1'b0;
         cnt_q      <= '0;
         level      <= 1'b0;
         rise_pulse <= 1'b0;
      end else begin
         meta_q     <= raw_in;
         sync_q     <= meta_q;
         rise_pulse <= flip_c & sync_q;
         if (sync_q == level) begin
            cnt_q <= '0;
         end else if (flip_c) begin
            cnt_q <= '0;
            level <= sync_q;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/mpu_nibble_entry.sv
// Board front end for the MPU command path: debounced step button captures the
// synced switch nibble into the next frame slot; a full frame is offered over
// valid/ready.
//   clk, rst    : clock, asynchronous active-high reset
//   sw_in       : raw switch nibble
//   btn_step    : raw step/enter button
//   btn_back    : raw backspace button (only with MPU_ENTRY_BACKSPACE_EN)
//   frm         : frame handshake (master side: frame_data, frame_valid, frame_ready)
//   entry_idx   : nibbles captured so far (FRAME_NIBBLES while presenting)
//   overrun     : sticky, step press arrived while presenting
// Build option: define MPU_ENTRY_BACKSPACE_EN to add the backspace button.
module mpu_nibble_entry
   import mpu_pkg::*;
#(
   parameter int unsigned FRAME_NIBBLES   = DEF_FRAME_NIBBLES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NIBBLE_W-1:0]         sw_in,
   input  logic                        btn_step,
`ifdef MPU_ENTRY_BACKSPACE_EN
   input  logic                        btn_back,
`endif
   mpu_nibble_entry_if.master          frm,
   output logic [$clog2(FRAME_NIBBLES):0] entry_idx,
   output logic                        overrun
);

   localparam int unsigned FRAME_W = NIBBLE_W * FRAME_NIBBLES;
   localparam int unsigned IDX_W   = $clog2(FRAME_NIBBLES) + 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_NIBBLES - 1);
   localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(FRAME_NIBBLES);

   // Switch synchroniser.
   logic [NIBBLE_W-1:0] sw_meta_q;
   logic [NIBBLE_W-1:0] sw_sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= sw_in;
         sw_sync_q <= sw_meta_q;
      end
   end

   // Step button conditioning; the pulse only counts while the level is high.
   logic step_level;
   logic step_rise;
   logic step_pulse;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_step_db (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (btn_step),
      .level      (step_level),
      .rise_pulse (step_rise)
   );

   assign step_pulse = step_rise & step_level;

`ifdef MPU_ENTRY_BACKSPACE_EN
   // Backspace button conditioning, identical path to the step button.
   logic back_level;
   logic back_rise;
   logic back_pulse;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_back_db (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (btn_back),
      .level      (back_level),
      .rise_pulse (back_rise)
   );

   assign back_pulse = back_rise & back_level;
`endif

   state_t             state_q,   state_d;
   logic [FRAME_W-1:0] frame_q,   frame_d;
   logic [IDX_W-1:0]   idx_q,     idx_d;
   logic               valid_q,   valid_d;
   logic               overrun_q, overrun_d;
   logic               handshake;

   // Entry state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_COLLECT;
         frame_q   <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   // Next-state: collect nibbles, present the frame, clear on handshake.
   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      handshake = valid_q & frm.frame_ready;

      unique case (state_q)
         ST_COLLECT: begin
`ifdef MPU_ENTRY_BACKSPACE_EN
            if (step_pulse && back_pulse) begin
               // Conflicting presses cancel each other.
               idx_d = idx_q;
            end else if (back_pulse) begin
               if (idx_q != '0) begin
                  idx_d = idx_q - IDX_W'(1);
                  for (int i = 0; i < FRAME_NIBBLES; i++) begin
                     if (IDX_W'(i) == idx_d) begin
                        frame_d[(FRAME_NIBBLES - 1 - i) * NIBBLE_W +: NIBBLE_W] = '0;
                     end
                  end
               end
            end else
`endif
            if (step_pulse) begin
               // Slot 0 lives in the MSBs of the frame.
               for (int i = 0; i < FRAME_NIBBLES; i++) begin
                  if (IDX_W'(i) == idx_q) begin
                     frame_d[(FRAME_NIBBLES - 1 - i) * NIBBLE_W +: NIBBLE_W] = sw_sync_q;
                  end
               end
               if (idx_q == IDX_LAST) begin
                  idx_d   = IDX_FULL;
                  state_d = ST_PRESENT;
                  valid_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         ST_PRESENT: begin
            // A press coinciding with the handshake is simply dropped.
            if (handshake) begin
               state_d   = ST_COLLECT;
               frame_d   = '0;
               idx_d     = '0;
               valid_d   = 1'b0;
               overrun_d = 1'b0;
            end else if (step_pulse) begin
               overrun_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_COLLECT;
         end
      endcase
   end

   assign frm.frame_data  = frame_q;
   assign frm.frame_valid = valid_q;
   assign entry_idx       = idx_q;
   assign overrun         = overrun_q;

endmodule

// File: tb/tb_mpu_nibble_entry.sv
// Directed self-checking bench for mpu_nibble_entry (FRAME_NIBBLES=4,
// DEBOUNCE_CYCLES=2, 8 ns clock). Inputs change and outputs are sampled on
// the falling edge.
module tb_mpu_nibble_entry;
   import mpu_pkg::*;

   localparam int unsigned N     = 4;
   localparam int unsigned IDX_W = $clog2(N) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [3:0]       sw_in = 4'h0;
   logic             btn_step = 1'b0;
`ifdef MPU_ENTRY_BACKSPACE_EN
   logic             btn_back = 1'b0;
`endif
   logic [IDX_W-1:0] entry_idx;
   logic             overrun;

   int checks   = 0;
   int failures = 0;

   mpu_nibble_entry_if #(.FRAME_NIBBLES(N)) frm_if ();

   mpu_nibble_entry #(
      .FRAME_NIBBLES   (N),
      .DEBOUNCE_CYCLES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw_in     (sw_in),
      .btn_step  (btn_step),
`ifdef MPU_ENTRY_BACKSPACE_EN
      .btn_back  (btn_back),
`endif
      .frm       (frm_if),
      .entry_idx (entry_idx),
      .overrun   (overrun)
   );

   always #4 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hold the button 5 cycles, release, let the release settle.
   task automatic press_step(input logic [3:0] v);
      @(negedge clk);
      sw_in    = v;
      btn_step = 1'b1;
      repeat (5) @(negedge clk);
      btn_step = 1'b0;
      repeat (6) @(negedge clk);
   endtask

`ifdef MPU_ENTRY_BACKSPACE_EN
   task automatic press_back();
      @(negedge clk);
      btn_back = 1'b1;
      repeat (5) @(negedge clk);
      btn_back = 1'b0;
      repeat (6) @(negedge clk);
   endtask
`endif

   task automatic handshake();
      @(negedge clk);
      frm_if.frame_ready = 1'b1;
      @(negedge clk);
      frm_if.frame_ready = 1'b0;
   endtask

   initial begin
      frm_if.frame_ready = 1'b0;

      // 1: reset with button held, then one pulse after release.
      sw_in    = 4'hF;
      btn_step = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid",   32'(frm_if.frame_valid), 32'h0);
      check("rst_idx",     32'(entry_idx),          32'h0);
      check("rst_overrun", 32'(overrun),            32'h0);
      check("rst_data",    32'(frm_if.frame_data),  32'h0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("held_idx",  32'(entry_idx),         32'h1);
      check("held_data", 32'(frm_if.frame_data), 32'hF000);
      repeat (10) @(negedge clk);
      check("held_once", 32'(entry_idx), 32'h1);
      btn_step = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst2_data", 32'(frm_if.frame_data), 32'h0);

      // 2: collect 1,0,A,5; ready is ignored while collecting.
      press_step(4'h1);
      check("idx1", 32'(entry_idx), 32'h1);
      frm_if.frame_ready = 1'b1;
      press_step(4'h0);
      frm_if.frame_ready = 1'b0;
      check("idx2", 32'(entry_idx), 32'h2);
      check("collect_valid", 32'(frm_if.frame_valid), 32'h0);
      press_step(4'hA);
      check("idx3", 32'(entry_idx), 32'h3);
      @(negedge clk);
      sw_in    = 4'h5;
      btn_step = 1'b1;
      repeat (4) @(negedge clk);
      check("valid_pulse_cycle", 32'(frm_if.frame_valid), 32'h0);
      @(negedge clk);
      check("valid_rise", 32'(frm_if.frame_valid), 32'h1);
      check("idx4",       32'(entry_idx),          32'h4);
      btn_step = 1'b0;
      repeat (6) @(negedge clk);
      check("frame_10A5", 32'(frm_if.frame_data), 32'h10A5);

      // 5: extra press while presenting -> overrun, data held.
      press_step(4'h8);
      check("ovr_data",  32'(frm_if.frame_data),  32'h10A5);
      check("ovr_flag",  32'(overrun),            32'h1);
      check("ovr_valid", 32'(frm_if.frame_valid), 32'h1);
      handshake();
      check("hs_valid",   32'(frm_if.frame_valid), 32'h0);
      check("hs_idx",     32'(entry_idx),          32'h0);
      check("hs_data",    32'(frm_if.frame_data),  32'h0);
      check("hs_overrun", 32'(overrun),            32'h0);

      // 3: second frame 1,0,C,3.
      press_step(4'h1);
      press_step(4'h0);
      press_step(4'hC);
      press_step(4'h3);
      check("frame_10C3", 32'(frm_if.frame_data),  32'h10C3);
      check("valid_10C3", 32'(frm_if.frame_valid), 32'h1);
      handshake();
      check("hs2_valid", 32'(frm_if.frame_valid), 32'h0);

      // 4: one-cycle glitch produces nothing.
      press_step(4'h7);
      @(negedge clk);
      btn_step = 1'b1;
      @(negedge clk);
      btn_step = 1'b0;
      repeat (8) @(negedge clk);
      check("glitch_idx",  32'(entry_idx),         32'h1);
      check("glitch_data", 32'(frm_if.frame_data), 32'h7000);

      // 6: async reset mid-frame.
      press_step(4'h2);
      check("mid_idx", 32'(entry_idx), 32'h2);
      #2 rst = 1'b1;
      #1;
      check("async_idx",  32'(entry_idx),         32'h0);
      check("async_data", 32'(frm_if.frame_data), 32'h0);
      @(negedge clk);
      rst = 1'b0;
`ifdef MPU_ENTRY_BACKSPACE_EN
      press_back();
      check("back_at0", 32'(entry_idx), 32'h0);
      press_step(4'hC);
      check("back_pre_idx",  32'(entry_idx),         32'h1);
      check("back_pre_data", 32'(frm_if.frame_data), 32'hC000);
      press_back();
      check("back_idx",  32'(entry_idx),         32'h0);
      check("back_data", 32'(frm_if.frame_data), 32'h0);
`endif
      press_step(4'hA);
      press_step(4'h3);
      press_step(4'h5);
      press_step(4'h8);
      check("frame_A358", 32'(frm_if.frame_data),  32'hA358);
      check("valid_A358", 32'(frm_if.frame_valid), 32'h1);
      check("idx_A358",   32'(entry_idx),          32'h4);

      // Step pulse in the handshake cycle: dropped, no overrun.
      @(negedge clk);
      sw_in    = 4'h9;
      btn_step = 1'b1;
      repeat (3) @(negedge clk);
      @(negedge clk);
      frm_if.frame_ready = 1'b1;
      @(negedge clk);
      frm_if.frame_ready = 1'b0;
      btn_step = 1'b0;
      check("hs3_valid",   32'(frm_if.frame_valid), 32'h0);
      check("hs3_overrun", 32'(overrun),            32'h0);
      check("hs3_idx",     32'(entry_idx),          32'h0);
      repeat (6) @(negedge clk);
      check("hs3_drop_idx",  32'(entry_idx),         32'h0);
      check("hs3_drop_data", 32'(frm_if.frame_data), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
